decoder_scan_n: RTL

//  Registered, parametrised N-to-2^N one-hot-low LED decoder with an automatic scan (chaser) mode.

---
 rtl/decoder_scan_n_if.sv | 38 +++
 rtl/decoder_scan_n.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/decoder_scan_n_if.sv
// rtl/decoder_scan_n_if.sv - switch/LED bundle for the scanning LED decoder
//
// Purpose: groups the board-side inputs and registered LED-side outputs of
//          decoder_scan_n into one interface.
// Signals:
//   enable   [EN_W]   enable code; the block is active only on a code match
//   switch   [SEL_W]  DIRECT: LED select; SCAN: start index on scan entry
//   mode     [1]      0 = DIRECT, 1 = SCAN
//   dir      [1]      scan direction: 0 = up, 1 = down
//   led      [OUT_W]  active-low one-hot LEDs (all ones = all off)
//   scan_idx [SEL_W]  current scan index
//   tick     [1]      one-cycle pulse on each scan step
// Modports: master drives the inputs, slave is the decoder itself.

interface decoder_scan_n_if #(
    parameter int SEL_W = 3,
    parameter int EN_W  = 3
);
    localparam int OUT_W = 2 ** SEL_W;

    logic [EN_W-1:0]  enable;
    logic [SEL_W-1:0] switch;
    logic             mode;
    logic             dir;
    logic [OUT_W-1:0] led;
    logic [SEL_W-1:0] scan_idx;
    logic             tick;

    modport master (
        output enable, switch, mode, dir,
        input  led, scan_idx, tick
    );

    modport slave (
        input  enable, switch, mode, dir,
        output led, scan_idx, tick
    );
endinterface

// File: rtl/decoder_scan_n.sv
// rtl/decoder_scan_n.sv - registered N-to-2^N active-low LED decoder with scan mode
//
// Purpose: drives one LED low either from the switch value (DIRECT) or from a
//          prescaled index that walks across the LEDs (SCAN). Any enable code
//          other than EN_MATCH blanks the bank. All outputs are registered.
// Ports:
//   clk  in  system clock, posedge
//   rst  in  synchronous reset, active-high
//   bus  decoder_scan_n_if.slave (enable, switch, mode, dir -> led, scan_idx, tick)
// Option: define DECODER_SCAN_PINGPONG_EN to make the scan bounce at the end
//         indices instead of wrapping; dir is then only latched on scan entry.

module decoder_scan_n #(
    parameter int             SEL_W    = 3,
    parameter int             EN_W     = 3,
    parameter logic [EN_W-1:0] EN_MATCH = 3'b100,
    parameter int             PRESCALE = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    decoder_scan_n_if.slave  bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] IDX_MAX  = SEL_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [OUT_W-1:0] r_led;
    logic [SEL_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    logic [OUT_W-1:0] w_led_d;
    logic [SEL_W-1:0] w_idx_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_tick_d;
    logic [SEL_W-1:0] w_step_idx;

`ifdef DECODER_SCAN_PINGPONG_EN
    logic r_dir;
    logic w_dir_d;
    logic w_step_dir;

    // Bounce at the ends: the step that would wrap turns around instead.
    always_comb begin
        w_step_dir = r_dir;
        if (!r_dir) begin
            if (r_idx == IDX_MAX) begin
                w_step_idx = r_idx - SEL_W'(1);
                w_step_dir = 1'b1;
            end else begin
                w_step_idx = r_idx + SEL_W'(1);
            end
        end else begin
            if (r_idx == '0) begin
                w_step_idx = r_idx + SEL_W'(1);
                w_step_dir = 1'b0;
            end else begin
                w_step_idx = r_idx - SEL_W'(1);
            end
        end
    end
`else
    // Modulo-OUT_W wrap falls out of the SEL_W-bit arithmetic.
    always_comb begin
        w_step_idx = bus.dir ? (r_idx - SEL_W'(1)) : (r_idx + SEL_W'(1));
    end
`endif

    always_comb begin
        w_next_state = S_IDLE;
        w_led_d      = '1;
        w_idx_d      = '0;
        w_cnt_d      = '0;
        w_tick_d     = 1'b0;
`ifdef DECODER_SCAN_PINGPONG_EN
        w_dir_d      = r_dir;
`endif
        if (bus.enable == EN_MATCH) begin
            w_next_state = bus.mode ? S_SCAN : S_DIRECT;
        end

        // State rule is resolved first, so an enable drop or mode change on
        // a step cycle never produces a step or a tick.
        case (w_next_state)
            S_DIRECT: begin
                w_led_d = ~(OUT_W'(1) << bus.switch);
                w_idx_d = r_idx;
            end
            S_SCAN: begin
                if (r_state != S_SCAN) begin
                    w_idx_d = bus.switch;
                    w_led_d = ~(OUT_W'(1) << bus.switch);
`ifdef DECODER_SCAN_PINGPONG_EN
                    w_dir_d = bus.dir;
`endif
                end else if (r_cnt == CNT_LAST) begin
                    w_tick_d = 1'b1;
                    w_idx_d  = w_step_idx;
                    w_led_d  = ~(OUT_W'(1) << w_step_idx);
`ifdef DECODER_SCAN_PINGPONG_EN
                    w_dir_d  = w_step_dir;
`endif
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                    w_idx_d = r_idx;
                    w_led_d = r_led;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_led   <= '1;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
`ifdef DECODER_SCAN_PINGPONG_EN
            r_dir   <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            r_led   <= w_led_d;
            r_idx   <= w_idx_d;
            r_cnt   <= w_cnt_d;
            r_tick  <= w_tick_d;
`ifdef DECODER_SCAN_PINGPONG_EN
            r_dir   <= w_dir_d;
`endif
        end
    end

    assign bus.led      = r_led;
    assign bus.scan_idx = r_idx;
    assign bus.tick     = r_tick;
endmodule
